sound_pwm: RTL and testbench



---
 rtl/sound_pwm.sv | 113 +++++++++++
 tb/tb_sound_pwm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_pwm.sv
// sound_pwm: per-scanline sound / disk-speed word consumer.
// The high byte of the fetched word is an offset-binary audio sample. It is
// volume-scaled and muted by the VIA sound enable, then driven out both as a
// parallel level and as a first-order sigma-delta bitstream. The low byte
// sets the duty cycle of a free-running disk-motor PWM.
module sound_pwm #(
  parameter int PWM_BITS = 8,
  parameter int SD_BITS  = 8
) (
  input  logic                clk8,
  input  logic                reset,
  input  logic [15:0]         memoryDataIn,
  input  logic                loadSound,
  input  logic                videoBusControl,
  input  logic [2:0]          soundVolume,
  input  logic                _soundDisable,
  output logic [SD_BITS-1:0]  audioLevel,
  output logic                audioSD,
  output logic                diskPwm,
  output logic                sampleStrobe
);

  localparam logic [SD_BITS-1:0] MID = {1'b1, {(SD_BITS-1){1'b0}}};

  logic [SD_BITS-1:0]        sample_q;
  logic [PWM_BITS-1:0]       pwm_q;
  logic [PWM_BITS-1:0]       cnt_q;
  logic [SD_BITS-1:0]        sd_acc_q;
  logic [SD_BITS-1:0]        scaled_q;
  logic                      vld0_q;
  logic                      vld1_q;
  logic                      capture_d;

  logic signed [SD_BITS-1:0] centered;
  logic [4:0]                vol_mult;
  logic signed [SD_BITS+2:0] cent_ext;
  logic signed [SD_BITS+2:0] vol_ext;
  logic signed [SD_BITS+2:0] product;
  logic [SD_BITS-1:0]        scaled_d;
  logic [SD_BITS:0]          sd_sum_d;
  logic                      unused_product_lsbs;

  assign capture_d = loadSound & videoBusControl;

  // Stage-1 arithmetic: center the sample, multiply by (volume+1), divide by 8
  // rounding toward -inf. Volume and mute are taken live at this stage.
  always_comb begin
    centered = sample_q ^ MID;
    vol_mult = {2'b00, soundVolume} + 5'd1;
    cent_ext = {{3{centered[SD_BITS-1]}}, centered};
    vol_ext  = {{(SD_BITS-2){1'b0}}, vol_mult};
    product  = cent_ext * vol_ext;
    scaled_d = _soundDisable ? '0 : product[SD_BITS+2:3];
    sd_sum_d = {1'b0, sd_acc_q} + {1'b0, audioLevel};
  end

  // The shifted-out remainder bits are intentionally discarded.
  assign unused_product_lsbs = ^product[2:0];

  // Stage 0: latch the fetched word only when the video side owns the bus.
  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      sample_q <= MID;
      pwm_q    <= '0;
      vld0_q   <= 1'b0;
    end else begin
      vld0_q <= capture_d;
      if (capture_d) begin
        sample_q <= memoryDataIn[15 -: SD_BITS];
        pwm_q    <= memoryDataIn[PWM_BITS-1:0];
      end
    end
  end

  // Stages 1 and 2: register the scaled value, then publish it with a strobe.
  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      scaled_q     <= '0;
      vld1_q       <= 1'b0;
      audioLevel   <= MID;
      sampleStrobe <= 1'b0;
    end else begin
      vld1_q       <= vld0_q;
      sampleStrobe <= vld1_q;
      if (vld0_q) scaled_q <= scaled_d;
      if (vld1_q) audioLevel <= scaled_q ^ MID;
    end
  end

  // First-order sigma-delta: the accumulator carry is the output bit, and the
  // accumulator keeps running across sample changes.
  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      sd_acc_q <= '0;
      audioSD  <= 1'b0;
    end else begin
      sd_acc_q <= sd_sum_d[SD_BITS-1:0];
      audioSD  <= sd_sum_d[SD_BITS];
    end
  end

  // Free-running disk PWM; a new compare value applies without realigning.
  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      diskPwm <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      diskPwm <= (cnt_q < pwm_q);
    end
  end

endmodule

// File: tb/tb_sound_pwm.sv
// tb_sound_pwm: directed scenarios plus randomized traffic for sound_pwm,
// checked every cycle against a latency/arithmetic reference model.
module tb_sound_pwm;

  logic        clk8 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] memoryDataIn = 16'h0000;
  logic        loadSound = 1'b0;
  logic        videoBusControl = 1'b0;
  logic [2:0]  soundVolume = 3'd0;
  logic        _soundDisable = 1'b0;
  logic [7:0]  audioLevel;
  logic        audioSD;
  logic        diskPwm;
  logic        sampleStrobe;

  sound_pwm #(.PWM_BITS(8), .SD_BITS(8)) dut (
    .clk8            (clk8),
    .reset           (reset),
    .memoryDataIn    (memoryDataIn),
    .loadSound       (loadSound),
    .videoBusControl (videoBusControl),
    .soundVolume     (soundVolume),
    ._soundDisable   (_soundDisable),
    .audioLevel      (audioLevel),
    .audioSD         (audioSD),
    .diskPwm         (diskPwm),
    .sampleStrobe    (sampleStrobe)
  );

  always #5 clk8 = ~clk8;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_level = 128;

  typedef struct {int due; int val;} ent_t;
  ent_t pend_q[$];
  ent_t out_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Signed sample times (vol+1), divided by 8 with floor; muted gives 0.
  function automatic int ref_scale(input int s, input int vol, input bit dis);
    int c, p;
    if (dis) return 0;
    c = s - 128;
    p = c * (vol + 1);
    if (p >= 0) return p / 8;
    return -((-p + 7) / 8);
  endfunction

  // One clock: update the reference with what is being driven, take the edge,
  // then compare level and strobe.
  task automatic step();
    int e;
    ent_t p;
    e = cyc;
    while (pend_q.size() > 0 && pend_q[0].due == e) begin
      p = pend_q.pop_front();
      out_q.push_back('{e + 1, ref_scale(p.val, int'(soundVolume), _soundDisable) + 128});
    end
    if (loadSound && videoBusControl)
      pend_q.push_back('{e + 1, int'(memoryDataIn[15:8])});
    @(posedge clk8);
    #1;
    if (out_q.size() > 0 && out_q[0].due == e) begin
      p = out_q.pop_front();
      exp_level = p.val;
      check("strobe", sampleStrobe, 1);
    end else begin
      check("strobe", sampleStrobe, 0);
    end
    check("level", audioLevel, exp_level);
    cyc++;
  endtask

  task automatic load_word(input logic [15:0] w, input logic [2:0] vol, input logic dis);
    soundVolume     = vol;
    _soundDisable   = dis;
    videoBusControl = 1'b1;
    memoryDataIn    = w;
    loadSound       = 1'b1;
    step();
    loadSound = 1'b0;
    step();
    step();
  endtask

  task automatic run_count(input bit sel_sd, input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      ones += sel_sd ? int'(audioSD) : int'(diskPwm);
    end
  endtask

  int ones;

  initial begin
    repeat (3) @(posedge clk8);
    #1;
    check("rst_level", audioLevel, 8'h80);
    check("rst_sd", audioSD, 0);
    check("rst_pwm", diskPwm, 0);
    check("rst_strobe", sampleStrobe, 0);
    reset = 1'b0;
    step();

    // Full volume, then reduced volume, then the most negative sample.
    load_word(16'hC040, 3'd7, 1'b0);
    check("t1_c0_v7", audioLevel, 8'hC0);
    step();
    check("t1_single_pulse", sampleStrobe, 0);
    load_word(16'hC040, 3'd3, 1'b0);
    check("t2_c0_v3", audioLevel, 8'hA0);
    load_word(16'h0040, 3'd0, 1'b0);
    check("t2_00_v0", audioLevel, 8'h70);

    // Mute, then unmute between capture and scale.
    load_word(16'hFF40, 3'd7, 1'b1);
    check("t3_muted", audioLevel, 8'h80);
    _soundDisable   = 1'b1;
    videoBusControl = 1'b1;
    memoryDataIn    = 16'hFF40;
    loadSound       = 1'b1;
    step();
    loadSound     = 1'b0;
    _soundDisable = 1'b0;
    step();
    step();
    check("t3_unmute_late", audioLevel, 8'hFF);

    // Level 0x40 with PWM 0x40, then an ignored load while bus not owned.
    load_word(16'h4040, 3'd7, 1'b0);
    check("t5_level40", audioLevel, 8'h40);
    videoBusControl = 1'b0;
    memoryDataIn    = 16'h0000;
    loadSound       = 1'b1;
    step();
    loadSound = 1'b0;
    step();
    step();
    check("t4_ignored_level", audioLevel, 8'h40);
    run_count(1'b0, 256, ones);
    check("t4_pwm_duty_kept", ones, 64);
    run_count(1'b1, 256, ones);
    check("t5_sd40_win0", ones, 64);
    run_count(1'b1, 256, ones);
    check("t5_sd40_win1", ones, 64);

    // Sigma-delta extremes.
    load_word(16'h0000, 3'd7, 1'b0);
    check("t5_level00", audioLevel, 8'h00);
    repeat (3) step();
    run_count(1'b1, 256, ones);
    check("t5_sd00", ones, 0);
    load_word(16'hFF00, 3'd7, 1'b0);
    repeat (3) step();
    run_count(1'b1, 256, ones);
    check("t5_sdff", ones, 255);

    // PWM duty at mid, zero and full scale.
    load_word(16'h8080, 3'd7, 1'b0);
    run_count(1'b0, 256, ones);
    check("t6_pwm80", ones, 128);
    load_word(16'h8000, 3'd7, 1'b0);
    run_count(1'b0, 256, ones);
    check("t6_pwm00", ones, 0);
    load_word(16'h80FF, 3'd7, 1'b0);
    run_count(1'b0, 256, ones);
    check("t6_pwmff", ones, 255);

    // Back-to-back loads: both strobe, in order, last one wins.
    videoBusControl = 1'b1;
    soundVolume     = 3'd7;
    memoryDataIn    = 16'h9011;
    loadSound       = 1'b1;
    step();
    memoryDataIn = 16'h6022;
    step();
    loadSound = 1'b0;
    repeat (3) step();
    check("b2b_last_wins", audioLevel, 8'h60);

    // Reset mid-operation with a sample in flight.
    load_word(16'hFFFF, 3'd7, 1'b0);
    memoryDataIn = 16'h2233;
    loadSound    = 1'b1;
    step();
    loadSound = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_level", audioLevel, 8'h80);
    check("mid_rst_sd", audioSD, 0);
    check("mid_rst_pwm", diskPwm, 0);
    check("mid_rst_strobe", sampleStrobe, 0);
    pend_q.delete();
    out_q.delete();
    exp_level = 128;
    @(posedge clk8);
    #1;
    reset = 1'b0;
    repeat (6) step();
    run_count(1'b0, 256, ones);
    check("post_rst_pwm", ones, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      loadSound       = ($urandom_range(0, 3) == 0);
      videoBusControl = ($urandom_range(0, 3) != 0);
      memoryDataIn    = 16'($urandom);
      soundVolume     = 3'($urandom_range(0, 7));
      _soundDisable   = ($urandom_range(0, 4) == 0);
      step();
    end
    loadSound = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
